// File: rtl/led_row_scanner_if.sv
// Signal bundle between the game-of-life frame source and the LED row scanner.
//   run               : scan enable from the controller
//   grid_in           : next generation, row r at grid_in[16*r +: 16]
//   frame_update_req  : level request to load grid_in, held until ack
//   frame_update_ack  : one-cycle pulse, grid_in has been captured
//   row_sel / row_en  : drive the 4-to-16 row decoder
//   col_data          : column bits of the lit row
//   frame_start       : one-cycle pulse at the start of each frame
// The master modport is the frame source / controller side; the scanner
// uses the slave modport.
interface led_row_scanner_if;
  logic         run;
  logic [255:0] grid_in;
  logic         frame_update_req;
  logic         frame_update_ack;
  logic [3:0]   row_sel;
  logic         row_en;
  logic [15:0]  col_data;
  logic         frame_start;

  modport master (
    output run, grid_in, frame_update_req,
    input  frame_update_ack, row_sel, row_en, col_data, frame_start
  );

  modport slave (
    input  run, grid_in, frame_update_req,
    output frame_update_ack, row_sel, row_en, col_data, frame_start
  );
endinterface

// File: rtl/led_row_scanner.sv
// Row-scan controller for a 16x16 LED matrix.
// Keeps a shadow copy of the grid and lights one row at a time for
// DWELL_CYCLES, followed by BLANK_CYCLES of darkness to avoid ghosting.
// A new grid is only taken at the frame boundary (LOAD state) so a frame is
// never shown half old / half new.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : led_row_scanner_if slave modport (run, grid, handshake,
//              decoder drive, column data, frame_start)
// Every output is a flop; its next value is derived from the next state so
// that outputs line up with the state they belong to.
module led_row_scanner #(
  parameter int DWELL_CYCLES = 2500,
  parameter int BLANK_CYCLES = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  led_row_scanner_if.slave   bus
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] DISPLAY = 2'd2;
  localparam logic [1:0] BLANK   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_sel_q, row_sel_d;
  logic          row_en_q, row_en_d;
  logic [15:0]   col_data_q, col_data_d;
  logic          ack_q, ack_d;
  logic          frame_start_q, frame_start_d;
  logic [15:0]   shadow_q [16];
  logic [15:0]   shadow_d [16];
  logic [15:0]   grid_rows [16];

  // Unpack the flat grid bus into per-row words.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rows
      assign grid_rows[gi] = bus.grid_in[16*gi +: 16];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_sel_d = row_sel_q;
    shadow_d  = shadow_q;

    case (state_q)
      IDLE: begin
        row_sel_d = 4'd0;
        cnt_d     = '0;
        if (bus.run) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        row_sel_d = 4'd0;
        cnt_d     = '0;
        state_d   = DISPLAY;
        if (bus.frame_update_req) begin
          for (int r = 0; r < 16; r++) begin
            shadow_d[r] = grid_rows[r];
          end
        end
      end
      DISPLAY: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = BLANK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d = '0;
          // run is only looked at here, so a stopping row still finishes.
          if (!bus.run) begin
            state_d   = IDLE;
            row_sel_d = 4'd0;
          end else if (row_sel_q == 4'd15) begin
            state_d   = LOAD;
            row_sel_d = 4'd0;
          end else begin
            state_d   = DISPLAY;
            row_sel_d = row_sel_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        row_sel_d = 4'd0;
      end
    endcase

    // Registered outputs follow the state being entered.
    row_en_d      = (state_d == DISPLAY);
    col_data_d    = row_en_d ? shadow_d[row_sel_d] : 16'd0;
    frame_start_d = (state_d == LOAD);
    // Ack marks the cycle after a capturing LOAD.
    ack_d         = (state_q == LOAD) && bus.frame_update_req;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      row_sel_q     <= 4'd0;
      row_en_q      <= 1'b0;
      col_data_q    <= 16'd0;
      ack_q         <= 1'b0;
      frame_start_q <= 1'b0;
      for (int r = 0; r < 16; r++) begin
        shadow_q[r] <= 16'd0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_sel_q     <= row_sel_d;
      row_en_q      <= row_en_d;
      col_data_q    <= col_data_d;
      ack_q         <= ack_d;
      frame_start_q <= frame_start_d;
      for (int r = 0; r < 16; r++) begin
        shadow_q[r] <= shadow_d[r];
      end
    end
  end

  assign bus.row_sel          = row_sel_q;
  assign bus.row_en           = row_en_q;
  assign bus.col_data         = col_data_q;
  assign bus.frame_update_ack = ack_q;
  assign bus.frame_start      = frame_start_q;

endmodule

// File: tb/tb_led_row_scanner.sv
// Directed bench for led_row_scanner with DWELL_CYCLES=4, BLANK_CYCLES=2
// (frame period 97). Outputs are sampled on the falling edge; inputs are
// driven on the falling edge as well.
module tb_led_row_scanner;

  localparam int DW     = 4;
  localparam int BL     = 2;
  localparam int ROWLEN = DW + BL;
  localparam int PERIOD = 16 * ROWLEN + 1;

  logic clk;
  logic reset_n;

  led_row_scanner_if bus ();

  led_row_scanner #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rows [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observed outputs packed as {frame_start, ack, row_en, row_sel, col_data}.
  function automatic logic [31:0] pack_obs();
    return {9'd0, bus.frame_start, bus.frame_update_ack, bus.row_en, bus.row_sel, bus.col_data};
  endfunction

  // Starts at the falling edge inside a LOAD cycle and checks n cycles
  // against the expected scan pattern. raise_c: cycle at which an all-ones
  // request is raised; stop_c: cycle at which run is dropped (-1 = none).
  task automatic scan(input string tag, input int n, input logic exp_ack,
                      input int raise_c, input int stop_c);
    int k, row, ph, idle_from;
    logic fs, ack, en;
    logic [3:0] sel;
    logic [15:0] col;
    idle_from = (stop_c >= 0) ? 1 + ((stop_c - 1) / ROWLEN + 1) * ROWLEN : 1 << 30;
    for (int c = 0; c < n; c++) begin
      fs = 0; ack = 0; en = 0; sel = 0; col = 0;
      if (c >= idle_from) begin
        // stopped: everything at rest values
      end else if (c % PERIOD == 0) begin
        fs = 1;
      end else begin
        k   = (c % PERIOD) - 1;
        row = k / ROWLEN;
        ph  = k % ROWLEN;
        en  = (ph < DW);
        sel = 4'(row);
        col = en ? exp_rows[row] : 16'd0;
        ack = exp_ack && (c % PERIOD == 1);
      end
      chk($sformatf("%s c=%0d", tag, c), pack_obs(), {9'd0, fs, ack, en, sel, col});
      if (c == raise_c) begin
        bus.grid_in = '1;
        bus.frame_update_req = 1'b1;
      end
      if (c == stop_c) bus.run = 1'b0;
      if (bus.frame_update_ack) bus.frame_update_req = 1'b0;
      @(negedge clk);
    end
    $display("scan %s: %0d cycles checked", tag, n);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.run = 1'b1;
    bus.frame_update_req = 1'b1;
    bus.grid_in = '1;
    for (int r = 0; r < 16; r++) exp_rows[r] = 16'd0;

    // Reset held with run and req asserted: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_hold %0d", i), pack_obs(), 32'd0);
    end
    $display("reset hold: outputs at rest");

    // Release: LOAD on the next edge.
    bus.frame_update_req = 1'b0;
    bus.grid_in = '0;
    reset_n = 1'b1;
    @(negedge clk);
    scan("free_run", PERIOD, 1'b0, -1, -1);

    // Walking-one update, requested at the LOAD.
    for (int r = 0; r < 16; r++) begin
      bus.grid_in[16*r +: 16] = 16'h0001 << r;
      exp_rows[r] = 16'h0001 << r;
    end
    bus.frame_update_req = 1'b1;
    scan("update", PERIOD, 1'b1, -1, -1);

    // Load all zeros.
    bus.grid_in = '0;
    bus.frame_update_req = 1'b1;
    for (int r = 0; r < 16; r++) exp_rows[r] = 16'd0;
    scan("load_zero", PERIOD, 1'b1, -1, -1);

    // Request during row 7 (second dwell cycle): frame stays dark.
    scan("midframe_req", PERIOD, 1'b0, 1 + 7 * ROWLEN + 1, -1);
    for (int r = 0; r < 16; r++) exp_rows[r] = 16'hFFFF;
    scan("midframe_apply", PERIOD, 1'b1, -1, -1);

    // Drop run during row 5 display.
    scan("stop", 50, 1'b0, -1, 1 + 5 * ROWLEN + 1);

    // Restart and reset asynchronously in row 9 display.
    bus.run = 1'b1;
    @(negedge clk);
    scan("pre_reset", 1 + 9 * ROWLEN + 2, 1'b0, -1, -1);
    chk("row9_lit", {15'd0, bus.row_en, bus.row_sel, 12'd0}, {15'd0, 1'b1, 4'd9, 12'd0});
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", pack_obs(), 32'd0);
    $display("async reset: outputs cleared off-edge");
    @(negedge clk);
    @(negedge clk);
    chk("reset_still", pack_obs(), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 16; r++) exp_rows[r] = 16'd0;
    scan("after_reset", PERIOD, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
